multi_debouncer: RTL and testbench
==================================

# multi_debouncer

Parametrised multi-channel debouncer for mechanical inputs (buttons, switches, limit contacts) entering the FPGA fabric. It replaces per-input single-channel debouncers with one block: a shared 1 ms tick prescaler, per-channel synchronisers and stability counters, and debounced levels. It also produces registered rise/fall pulses and a long-press (hold) indication, so downstream control logic needs no edge detectors of its own.

## Interface
- CLOCK_FREQUENCY, 50: clk frequency in MHz.
- DEBOUNCE_TIME, 5: required stable time in ms; legal range ≥2.
- HOLD_TIME, 1000: long-press time in ms; 0 disables hold logic, and hold outputs stay 0.
- N_CHANNELS, 8: number of independent inputs; ≥1.
- INIT_VALUE, {N_CHANNELS{1'b0}}: per-channel debounced level after reset.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  N_CHANNELS  raw asynchronous inputs.
- data_out  out  N_CHANNELS  debounced levels.
- rise  out  N_CHANNELS  one-cycle pulse when data_out goes 0→1.
- fall  out  N_CHANNELS  one-cycle pulse when data_out goes 1→0.
- hold_pulse  out  N_CHANNELS  one-cycle pulse when data_out has been 1 for HOLD_TIME ms.
- held  out  N_CHANNELS  level: high from hold_pulse until data_out falls.

## Operation
- Reset (async assert, sync deassert expected upstream):
  - data_out = INIT_VALUE; rise, fall, hold_pulse, held = 0.
  - Prescaler, all counters and synchroniser FFs are cleared. Synchroniser FFs load INIT_VALUE.
- Prescaler: counts 0..CLOCK_FREQUENCY*1000−1 and asserts `tick` for one cycle on wrap (every 1 ms). It is shared by all channels.
- Per channel:
  - 2-FF synchroniser → sync; prev = sync delayed one cycle.
  - Stability counter stab (0..DEBOUNCE_TIME, saturating):
    - sync≠prev → stab = 0. Clear wins over a simultaneous tick.
    - Else, if tick and stab<DEBOUNCE_TIME → stab+1.
  - Update: if stab==DEBOUNCE_TIME and sync==prev and sync≠data_out, then the next edge sets data_out = sync. In the same cycle, rise or fall is asserted for one cycle.
  - Hold counter hcnt (0..HOLD_TIME, saturating):
    - Cleared whenever data_out==0.
    - While data_out==1, increments on tick.
    - On the increment that reaches HOLD_TIME: hold_pulse for one cycle, and held = 1.
    - held clears on the same edge that data_out falls (same cycle as fall).
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Widths:
  - Prescaler width = $clog2(CLOCK_FREQUENCY*1000).
  - stab width = $clog2(DEBOUNCE_TIME+1).
  - hcnt width = $clog2(HOLD_TIME+1), min 1.
  - All comparisons use unsigned values; no wrap is possible because counters saturate.

## Timing
- Synchroniser latency: 2 cycles from data_in to sync.
- Tick quantisation: after the last input change, data_out updates after a stable interval strictly greater than (DEBOUNCE_TIME−1) ms and at most DEBOUNCE_TIME ms, plus 4 cycles (2 sync + 1 prev + 1 update).
- Glitches of ≤(DEBOUNCE_TIME−1) ms are never passed.
- rise/fall are coincident with the data_out transition cycle.
- hold_pulse occurs HOLD_TIME ticks after the rise cycle, with up to 1 ms of quantisation.
- A bounce arriving mid-count restarts that channel only; the prescaler is never reset except by reset.
- Reset asserted mid-operation forces outputs to reset values immediately (asynchronously). Counting restarts from zero after release.

## Structure
- Package debounce_pkg:
  - Width helper function (clog2 with min 1).
  - Tick-period constant expression: CLOCK_FREQUENCY*1000.
- Sub-module debounce_channel:
  - One instance per channel, via a generate loop.
  - Contains the synchroniser, stab, hcnt and the output registers.
  - Inputs: tick, clk, reset.
- Top level holds only the prescaler.

## Test plan
Parameters for all scenarios: CLOCK_FREQUENCY=1 (tick every 1000 cycles), DEBOUNCE_TIME=3, HOLD_TIME=10, N_CHANNELS=4, INIT_VALUE=4'b1000.
- Reset: assert reset at any time → data_out=4'b1000 immediately; rise, fall, hold_pulse, held = 0; data_out stays 4'b1000 for 5000 cycles with constant inputs equal to INIT_VALUE.
- Clean step: data_in[0] 0→1 → data_out[0] rises between 2001 and 3004 cycles later, with a single-cycle rise[0] in that cycle; other bits unchanged.
- Bounce: toggle data_in[1] every 500 cycles for 6000 cycles, then hold at 1 → no data_out[1] change during bouncing; rise within 2001..3004 cycles after the last edge.
- Glitch: data_in[2] high for 1500 cycles → no data_out, rise or fall activity.
- Long press: data_in[0] held high 15 ms → hold_pulse[0] once, 10 ticks after rise[0], with held[0] high from then on. Release → fall[0] and held[0]→0 in the same cycle.
- Simultaneous, plus reset mid-count:
  - data_in[0] 0→1 and data_in[3] 1→0 on the same cycle → rise[0] and fall[3] in the same cycle.
  - Reset while stab=2 → after release, a full 2001..3004-cycle count is required before any update.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: counter width sizing and
// the 1 ms tick period derived from the clock frequency.
package debounce_pkg;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(value)) w++;
    return w;
  endfunction

  // Clock cycles per 1 ms tick for a clock given in MHz.
  function automatic int tick_period(input int freq_mhz);
    return freq_mhz * 1000;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-FF synchroniser, stability counter saturating at
// DEBOUNCE_TIME ticks, registered level with rise/fall pulses, and an
// optional long-press counter producing hold_pulse/held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_TIME = 5,
  parameter int   HOLD_TIME     = 1000,
  parameter logic INIT_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall,
  output logic hold_pulse,
  output logic held
);

  localparam int SW = clog2_min1(DEBOUNCE_TIME + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_TIME);

  logic          meta;
  logic          sync;
  logic          prev;
  logic [SW-1:0] stab;
  logic          update;

  // Synchroniser chain plus one-cycle history used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= INIT_VALUE;
      sync <= INIT_VALUE;
      prev <= INIT_VALUE;
    end else begin
      meta <= data_in;
      sync <= meta;
      prev <= sync;
    end
  end

  // Stability counter: any change restarts it, even on a tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab <= '0;
    end else if (sync != prev) begin
      stab <= '0;
    end else if (tick && (stab < STAB_MAX)) begin
      stab <= stab + 1'b1;
    end
  end

  assign update = (stab == STAB_MAX) && (sync == prev) && (sync != data_out);

  // Debounced level with edge pulses coincident with the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= INIT_VALUE;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= update && sync;
      fall <= update && !sync;
      if (update) data_out <= sync;
    end
  end

  if (HOLD_TIME > 0) begin : g_hold
    localparam int HW = clog2_min1(HOLD_TIME + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TIME);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIME - 1);

    logic [HW-1:0] hcnt;

    // Long-press timer; held drops on the same edge the level falls.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hcnt       <= '0;
        hold_pulse <= 1'b0;
        held       <= 1'b0;
      end else begin
        hold_pulse <= 1'b0;
        if (!data_out) begin
          hcnt <= '0;
        end else if (tick && (hcnt < HOLD_MAX)) begin
          hcnt <= hcnt + 1'b1;
          if (hcnt == HOLD_LAST) begin
            hold_pulse <= 1'b1;
            held       <= 1'b1;
          end
        end
        if (update && !sync) begin
          hold_pulse <= 1'b0;
          held       <= 1'b0;
        end
      end
    end
  end else begin : g_no_hold
    assign hold_pulse = 1'b0;
    assign held       = 1'b0;
  end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer top: a shared 1 ms tick prescaler feeding one
// independent debounce_channel per input.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50,
  parameter int DEBOUNCE_TIME   = 5,
  parameter int HOLD_TIME       = 1000,
  parameter int N_CHANNELS      = 8,
  parameter logic [N_CHANNELS-1:0] INIT_VALUE = {N_CHANNELS{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] data_in,
  output logic [N_CHANNELS-1:0] data_out,
  output logic [N_CHANNELS-1:0] rise,
  output logic [N_CHANNELS-1:0] fall,
  output logic [N_CHANNELS-1:0] hold_pulse,
  output logic [N_CHANNELS-1:0] held
);

  localparam int PERIOD = tick_period(CLOCK_FREQUENCY);
  localparam int PW     = clog2_min1(PERIOD);
  localparam logic [PW-1:0] PRE_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // Free-running prescaler; tick is a registered one-cycle strobe on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TIME(DEBOUNCE_TIME),
      .HOLD_TIME    (HOLD_TIME),
      .INIT_VALUE   (INIT_VALUE[i])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .data_in   (data_in[i]),
      .data_out  (data_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .hold_pulse(hold_pulse[i]),
      .held      (held[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: a table of settle-and-check steps
// followed by hand-written multi-cycle corner cases.
module tb_multi_debouncer;

  localparam logic [3:0] INIT = 4'b1000;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] hold_pulse;
  logic [3:0] held;

  int checks;
  int errors;

  multi_debouncer #(
    .CLOCK_FREQUENCY(1),
    .DEBOUNCE_TIME  (3),
    .HOLD_TIME      (10),
    .N_CHANNELS     (4),
    .INIT_VALUE     (INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .rise      (rise),
    .fall      (fall),
    .hold_pulse(hold_pulse),
    .held      (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    int         cycles;
    logic [3:0] exp_out;
    logic [3:0] exp_held;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Reset with inputs at INIT; release #1 after an edge (that edge is edge 0).
  task automatic do_reset();
    data_in = INIT;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Count edges until data_out[ch] reaches lvl; -1 on timeout.
  task automatic wait_level(input int ch, input logic lvl, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (data_out[ch] == lvl) return;
    end
    n = -1;
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int m;
    int bad;
    int pulses;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    data_in = INIT;

    vecs[0] = '{4'b1000, 4000, 4'b1000, 4'b0000};
    vecs[1] = '{4'b1001, 4000, 4'b1001, 4'b0000};
    vecs[2] = '{4'b1011, 4000, 4'b1011, 4'b1000};
    vecs[3] = '{4'b0011, 4000, 4'b0011, 4'b0000};
    vecs[4] = '{4'b0011, 4000, 4'b0011, 4'b0001};
    vecs[5] = '{4'b0110, 4000, 4'b0110, 4'b0010};
    vecs[6] = '{4'b0000, 4000, 4'b0000, 4'b0000};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", 32'(data_out), 32'(INIT));
    check("reset_pulses", 32'({rise, fall, hold_pulse, held}), 32'd0);

    // Table of settle-and-check steps from a fresh reset.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      data_in = vecs[i].din;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_held", i), 32'(held), 32'(vecs[i].exp_held));
      check($sformatf("vec%0d_pulses", i), 32'({rise, fall, hold_pulse}), 32'd0);
    end

    // Asynchronous reset mid-cycle, then 5000 quiet cycles.
    @(posedge clk);
    #2 reset = 1'b1;
    data_in = INIT;
    #1;
    check("async_reset_data_out", 32'(data_out), 32'(INIT));
    check("async_reset_pulses", 32'({rise, fall, hold_pulse, held}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      if (data_out !== INIT || (rise | fall) !== 4'b0000) bad++;
    end
    check("reset_quiet_5000", 32'(bad), 32'd0);

    // Clean step on channel 0.
    do_reset();
    data_in = 4'b1001;
    wait_level(0, 1'b1, 4000, n);
    check_range("step_latency", n, 2001, 3004);
    check("step_rise", 32'(rise), 32'b0001);
    check("step_data_out", 32'(data_out), 32'b1001);
    @(posedge clk);
    #1;
    check("step_rise_single", 32'(rise), 32'd0);

    // Bounce on channel 1: 500-cycle toggles for 6000 cycles, then hold high.
    do_reset();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      data_in[1] = ~data_in[1];
      for (int i = 0; i < 500; i++) begin
        @(posedge clk);
        #1;
        if (data_out[1] !== 1'b0 || rise[1] !== 1'b0) bad++;
      end
    end
    check("bounce_quiet", 32'(bad), 32'd0);
    data_in[1] = 1'b1;
    wait_level(1, 1'b1, 4000, n);
    check_range("bounce_latency", n, 2001, 3004);
    check("bounce_rise", 32'(rise), 32'b0010);

    // Glitch of 1500 cycles on channel 2 must not pass.
    do_reset();
    data_in[2] = 1'b1;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i == 1500) data_in[2] = 1'b0;
      @(posedge clk);
      #1;
      if (data_out[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0) bad++;
    end
    check("glitch_blocked", 32'(bad), 32'd0);

    // Long press on channel 0 for 15 ms.
    do_reset();
    data_in = 4'b1001;
    wait_level(0, 1'b1, 4000, n);
    check("press_rise", 32'(rise[0]), 32'd1);
    m = 0;
    bad = 0;
    while (m < 11000) begin
      @(posedge clk);
      #1;
      m++;
      if (hold_pulse[0]) break;
      if (held[0]) bad++;
    end
    check_range("hold_delay", m, 9001, 10000);
    check("held_before_pulse", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    check("hold_pulse_single", 32'(hold_pulse[0]), 32'd0);
    check("held_set", 32'(held[0]), 32'd1);
    pulses = 0;
    bad = 0;
    for (int i = n + m + 1; i < 15000; i++) begin
      @(posedge clk);
      #1;
      if (hold_pulse[0]) pulses++;
      if (!held[0]) bad++;
    end
    data_in = 4'b1000;
    n = 0;
    while (n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (!data_out[0]) break;
      if (hold_pulse[0]) pulses++;
      if (!held[0]) bad++;
    end
    check("hold_no_repeat", 32'(pulses), 32'd0);
    check("held_stays", 32'(bad), 32'd0);
    check("release_data_out", 32'(data_out[0]), 32'd0);
    check("release_fall", 32'(fall[0]), 32'd1);
    check("release_held_clear", 32'(held[0]), 32'd0);

    // Simultaneous rise on channel 0 and fall on channel 3.
    do_reset();
    data_in = 4'b0001;
    n = 0;
    while (n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (data_out[0] || !data_out[3]) break;
    end
    check("simul_rise_fall", 32'({rise, fall}), 32'h18);
    check("simul_data_out", 32'(data_out), 32'b0001);

    // Reset while the stability counter sits at 2 restarts the full count.
    do_reset();
    data_in = 4'b1001;
    repeat (2003) @(posedge clk);
    #1;
    check("premature_update", 32'(data_out), 32'(INIT));
    #2 reset = 1'b1;
    #1;
    check("midcount_reset_out", 32'(data_out), 32'(INIT));
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_level(0, 1'b1, 4000, n);
    check_range("restart_latency", n, 2001, 3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
